// File: rtl/ssram_burst.sv
// rtl/ssram_burst.sv - single-port synchronous SRAM with incrementing/wrapping burst engine
//
// Purpose: line storage behind the cache controller. One burst command at a time;
// write bursts take per-byte strobes, read bursts stream out through a 2-entry
// buffer under valid/ready backpressure. Wrapping bursts are critical-word-first.
// Optional build macro: SSRAM_BURST_OUTREG_EN adds a register stage after the
// RAM output (first-beat latency 3 instead of 2, throughput unchanged).
//
// Ports:
//   clk, resetn                  clock (posedge), asynchronous active-low reset
//   iCmdValid/oCmdReady          command handshake (ready only when idle)
//   iCmdWr, iCmdWrap             1=write/0=read, 1=wrapping/0=incrementing
//   iCmdAddr[AW], iCmdLen[LW]    start word address, beats minus one
//   iWValid/oWReady, iWData, iWStrb   write beat stream
//   oRValid/iRReady, oRData, oRLast   read beat stream
//   oBusy                        engine not idle
module ssram_burst #(
   parameter int AW = 18,
   parameter int DW = 32,
   parameter int LW = 4
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            iCmdValid,
   output logic            oCmdReady,
   input  logic            iCmdWr,
   input  logic            iCmdWrap,
   input  logic [AW-1:0]   iCmdAddr,
   input  logic [LW-1:0]   iCmdLen,
   input  logic            iWValid,
   output logic            oWReady,
   input  logic [DW-1:0]   iWData,
   input  logic [DW/8-1:0] iWStrb,
   output logic            oRValid,
   input  logic            iRReady,
   output logic [DW-1:0]   oRData,
   output logic            oRLast,
   output logic            oBusy
);
   localparam int BW = DW / 8;

   typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
   state_t state, stateNxt;

   logic [AW-1:0] startQ;
   logic [LW-1:0] lenQ;
   logic [LW-1:0] beatQ;
   logic          wrapQ;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   // Read pipeline: stage 1 is the synchronous RAM output.
   logic [DW-1:0] rdData1;
   logic          pend1, last1;
`ifdef SSRAM_BURST_OUTREG_EN
   logic [DW-1:0] rdData2;
   logic          pend2, last2;
`endif

   // Two-entry output buffer; buf0 is the head and doubles as oRData so the
   // last value is held when the buffer drains.
   logic [DW-1:0] buf0, buf1;
   logic          bufLast0, bufLast1;
   logic [1:0]    bufCnt;

   logic          cmdAcc, wBeat, issue, pop, push, pushLast, lastBeat;
   logic [DW-1:0] pushData;
   logic [2:0]    inFlight, occ;
   logic [AW-1:0] curAddr, wrapMask;
   logic [LW:0]   lenP1;

   // Address generation: bits under wrapMask advance modulo the burst size,
   // bits above it stay at the start address. Non-power-of-two wraps and
   // incrementing bursts use a full mask, i.e. plain start + beat.
   always_comb begin
      lenP1    = {1'b0, lenQ} + (LW+1)'(1);
      wrapMask = '1;
      if (wrapQ && ((lenP1 & {1'b0, lenQ}) == '0))
         wrapMask = AW'(lenQ);
      curAddr  = (startQ & ~wrapMask) | ((startQ + AW'(beatQ)) & wrapMask);
   end

   always_comb begin
      oRValid = (bufCnt != 2'd0);
      pop     = oRValid & iRReady;
`ifdef SSRAM_BURST_OUTREG_EN
      inFlight = {2'b00, pend1} + {2'b00, pend2};
      push     = pend2;
      pushData = rdData2;
      pushLast = last2;
`else
      inFlight = {2'b00, pend1};
      push     = pend1;
      pushData = rdData1;
      pushLast = last1;
`endif
      occ = {1'b0, bufCnt} + inFlight;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         state <= IDLE;
      else
         state <= stateNxt;
   end

   always_comb begin
      stateNxt  = state;
      oCmdReady = 1'b0;
      oWReady   = 1'b0;
      cmdAcc    = 1'b0;
      wBeat     = 1'b0;
      issue     = 1'b0;
      lastBeat  = (beatQ == lenQ);
      case (state)
         IDLE: begin
            oCmdReady = 1'b1;
            cmdAcc    = iCmdValid;
            if (iCmdValid)
               stateNxt = iCmdWr ? WRITE : READ;
         end
         WRITE: begin
            oWReady = 1'b1;
            wBeat   = iWValid;
            if (iWValid && lastBeat)
               stateNxt = IDLE;
         end
         READ: begin
            // A slot freed by this cycle's pop may be reused immediately.
            issue = (occ < (pop ? 3'd3 : 3'd2));
            if (issue && lastBeat)
               stateNxt = DRAIN;
         end
         DRAIN: begin
            if (occ == 3'd0)
               stateNxt = IDLE;
         end
         default: stateNxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         startQ   <= '0;
         lenQ     <= '0;
         wrapQ    <= 1'b0;
         beatQ    <= '0;
         pend1    <= 1'b0;
         last1    <= 1'b0;
`ifdef SSRAM_BURST_OUTREG_EN
         pend2    <= 1'b0;
         last2    <= 1'b0;
`endif
         buf0     <= '0;
         buf1     <= '0;
         bufLast0 <= 1'b0;
         bufLast1 <= 1'b0;
         bufCnt   <= 2'd0;
      end else begin
         if (cmdAcc) begin
            startQ <= iCmdAddr;
            lenQ   <= iCmdLen;
            wrapQ  <= iCmdWrap;
            beatQ  <= '0;
         end else if (wBeat || issue) begin
            beatQ  <= beatQ + LW'(1);
         end
         pend1 <= issue;
         last1 <= issue & lastBeat;
`ifdef SSRAM_BURST_OUTREG_EN
         pend2 <= pend1;
         last2 <= last1;
`endif
         case (bufCnt)
            2'd0: begin
               if (push) begin
                  buf0     <= pushData;
                  bufLast0 <= pushLast;
                  bufCnt   <= 2'd1;
               end
            end
            2'd1: begin
               if (push && pop) begin
                  buf0     <= pushData;
                  bufLast0 <= pushLast;
               end else if (push) begin
                  buf1     <= pushData;
                  bufLast1 <= pushLast;
                  bufCnt   <= 2'd2;
               end else if (pop) begin
                  bufCnt   <= 2'd0;
               end
            end
            default: begin
               if (pop) begin
                  buf0     <= buf1;
                  bufLast0 <= bufLast1;
                  if (push) begin
                     buf1     <= pushData;
                     bufLast1 <= pushLast;
                  end else begin
                     bufCnt   <= 2'd1;
                  end
               end
            end
         endcase
      end
   end

   // RAM array and read data stages carry no reset.
   always_ff @(posedge clk) begin
      if (wBeat) begin
         for (int b = 0; b < BW; b++)
            if (iWStrb[b])
               mem[curAddr][8*b +: 8] <= iWData[8*b +: 8];
      end
      if (issue)
         rdData1 <= mem[curAddr];
`ifdef SSRAM_BURST_OUTREG_EN
      rdData2 <= rdData1;
`endif
   end

   assign oRData = buf0;
   assign oRLast = oRValid & bufLast0;
   assign oBusy  = (state != IDLE);

endmodule

// File: tb/tb_ssram_burst.sv
// tb/tb_ssram_burst.sv - self-checking bench for ssram_burst
module tb_ssram_burst;
`ifdef SSRAM_BURST_OUTREG_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic        clk, resetn;
   logic        iCmdValid, oCmdReady, iCmdWr, iCmdWrap;
   logic [17:0] iCmdAddr;
   logic [3:0]  iCmdLen;
   logic        iWValid, oWReady;
   logic [31:0] iWData;
   logic [3:0]  iWStrb;
   logic        oRValid, iRReady, oRLast, oBusy;
   logic [31:0] oRData;

   ssram_burst #(.AW(18), .DW(32), .LW(4)) dut (
      .clk(clk), .resetn(resetn),
      .iCmdValid(iCmdValid), .oCmdReady(oCmdReady), .iCmdWr(iCmdWr), .iCmdWrap(iCmdWrap),
      .iCmdAddr(iCmdAddr), .iCmdLen(iCmdLen),
      .iWValid(iWValid), .oWReady(oWReady), .iWData(iWData), .iWStrb(iWStrb),
      .oRValid(oRValid), .iRReady(iRReady), .oRData(oRData), .oRLast(oRLast),
      .oBusy(oBusy)
   );

   typedef struct {logic [31:0] d; logic l;} exp_t;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          acceptCyc = 0;
   bit          latPending = 0;
   int          rrMode = 0;
   int          rrIdx = 0;
   logic [31:0] mdl [int];
   exp_t        expQ[$];
   logic [31:0] gotQ[$];
   int          beatCycQ[$];
   logic [31:0] wdQ[$];
   logic [3:0]  wsQ[$];

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      case (rrMode)
         0: iRReady = 1'b1;
         1: iRReady = 1'($urandom_range(0, 1));
         default: begin
            iRReady = (rrIdx % 3 == 0);
            rrIdx++;
         end
      endcase
   end

   // Address of beat i from the burst rules, written with plain arithmetic.
   function automatic int beatAddr(input int start, input int len, input bit wrap, input int i);
      int n;
      n = len + 1;
      if (wrap && ((n & (n - 1)) == 0))
         return (start / n) * n + ((start % n + i) % n);
      return (start + i) % (1 << 18);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // Compare process: every negedge with the read stream live.
   initial begin : monitor
      bit          stallPrev;
      logic [31:0] stallData;
      stallPrev = 0;
      stallData = '0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            stallPrev = 0;
            latPending = 0;
         end else begin
            if (stallPrev) begin
               checks++;
               if (!oRValid || oRData !== stallData) begin
                  failures++;
                  $display("FAIL stall_hold valid=%0b data=%h required valid=1 data=%h", oRValid, oRData, stallData);
               end
            end
            if (oRValid) begin
               if (latPending) begin
                  checks++;
                  if (cyc - acceptCyc != LAT) begin
                     failures++;
                     $display("FAIL first_latency got=%0d required=%0d", cyc - acceptCyc, LAT);
                  end
                  latPending = 0;
               end
               checks++;
               if (expQ.size() == 0) begin
                  failures++;
                  $display("FAIL spurious_beat data=%h required no beat", oRData);
               end else begin
                  if (oRData !== expQ[0].d || oRLast !== expQ[0].l) begin
                     failures++;
                     $display("FAIL read_beat data=%h last=%0b required data=%h last=%0b",
                              oRData, oRLast, expQ[0].d, expQ[0].l);
                  end
                  if (iRReady) begin
                     gotQ.push_back(oRData);
                     beatCycQ.push_back(cyc);
                     void'(expQ.pop_front());
                  end
               end
            end else if (oRLast) begin
               checks++;
               failures++;
               $display("FAIL last_without_valid oRLast=1 required 0");
            end
            stallPrev = oRValid && !iRReady;
            stallData = oRData;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         failures++;
         $display("FAIL %s got=%h required=%h", name, got, req);
      end
   endtask

   task automatic doCmd(input bit wr, input bit wrap, input int addr, input int len);
      bit rdy;
      int n;
      n = 0;
      iCmdValid = 1;
      iCmdWr = wr;
      iCmdWrap = wrap;
      iCmdAddr = 18'(addr);
      iCmdLen = 4'(len);
      do begin
         @(negedge clk);
         rdy = oCmdReady;
         @(posedge clk);
         #1;
         n++;
      end while (!rdy && n < 200);
      iCmdValid = 0;
      acceptCyc = cyc;
      checks++;
      if (!rdy) begin
         failures++;
         $display("FAIL cmd_accept_timeout ready=0 required=1");
      end
   endtask

   task automatic writeBurst(input int addr, input int len, input bit wrap);
      int i, n, a;
      bit rdy;
      doCmd(1, wrap, addr, len);
      i = 0;
      n = 0;
      while (i <= len && n < 400) begin
         iWValid = ($urandom_range(0, 3) != 0);
         iWData = wdQ[i];
         iWStrb = wsQ[i];
         @(negedge clk);
         rdy = iWValid && oWReady;
         @(posedge clk);
         #1;
         if (rdy) begin
            a = beatAddr(addr, len, wrap, i);
            mdl[a] = merge(mdl.exists(a) ? mdl[a] : 32'h0, wdQ[i], wsQ[i]);
            i++;
         end
         n++;
      end
      iWValid = 0;
      chk("write_beats_done", 32'(i), 32'(len + 1));
      chk("write_end_idle", {31'b0, oBusy}, 32'h0);
      wdQ.delete();
      wsQ.delete();
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while ((expQ.size() != 0 || oBusy) && n < 600) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (n >= 600) begin
         failures++;
         $display("FAIL drain_timeout pending=%0d required=0", expQ.size());
      end
   endtask

   task automatic readBurst(input int addr, input int len, input bit wrap);
      int a;
      gotQ.delete();
      beatCycQ.delete();
      for (int i = 0; i <= len; i++) begin
         a = beatAddr(addr, len, wrap, i);
         expQ.push_back('{d: mdl[a], l: (i == len)});
      end
      doCmd(0, wrap, addr, len);
      latPending = 1;
      waitIdle();
      chk("read_beat_count", 32'(gotQ.size()), 32'(len + 1));
   endtask

   initial begin
      logic [31:0] lit[4];
      int          start, len, n;
      bit          wrap;

      resetn = 0;
      iCmdValid = 0; iCmdWr = 0; iCmdWrap = 0; iCmdAddr = '0; iCmdLen = '0;
      iWValid = 0; iWData = '0; iWStrb = '0; iRReady = 1;

      @(negedge clk);
      chk("rst_cmd_ready", {31'b0, oCmdReady}, 32'h1);
      chk("rst_w_ready", {31'b0, oWReady}, 32'h0);
      chk("rst_r_valid", {31'b0, oRValid}, 32'h0);
      chk("rst_r_last", {31'b0, oRLast}, 32'h0);
      chk("rst_r_data", oRData, 32'h0);
      chk("rst_busy", {31'b0, oBusy}, 32'h0);
      @(posedge clk);
      #1;
      resetn = 1;

      // Model pins.
      chk("model_wrap_addr", 32'(beatAddr('h0D, 3, 1, 3)), 32'h0C);
      chk("model_inc_rollover", 32'(beatAddr('h3FFFF, 3, 0, 1)), 32'h0);
      chk("model_nonpow2_wrap", 32'(beatAddr('h0D, 2, 1, 2)), 32'h0F);

      // Write beats outside WRITE are refused.
      iWValid = 1; iWData = 32'hDEADBEEF; iWStrb = 4'hF;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("idle_w_ready", {31'b0, oWReady}, 32'h0);
         @(posedge clk);
         #1;
      end
      iWValid = 0;

      // Incrementing write then read at 0x10.
      rrMode = 0;
      for (int k = 0; k < 4; k++) begin wdQ.push_back(32'hA0 + k); wsQ.push_back(4'hF); end
      writeBurst('h10, 3, 0);
      readBurst('h10, 3, 0);
      if (gotQ.size() == 4) begin
         lit = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
         for (int k = 0; k < 4; k++) chk("inc_read_literal", gotQ[k], lit[k]);
         chk("inc_read_throughput", 32'(beatCycQ[3] - beatCycQ[0]), 32'd3);
      end

      // Wrapping read, critical word first.
      for (int k = 0; k < 4; k++) begin wdQ.push_back(32'hC + k); wsQ.push_back(4'hF); end
      writeBurst('h0C, 3, 0);
      readBurst('h0D, 3, 1);
      if (gotQ.size() == 4) begin
         lit = '{32'hD, 32'hE, 32'hF, 32'hC};
         for (int k = 0; k < 4; k++) chk("wrap_read_literal", gotQ[k], lit[k]);
      end

      // Byte strobes.
      wdQ.push_back(32'hFFFFFFFF); wsQ.push_back(4'hF);
      writeBurst('h20, 0, 0);
      wdQ.push_back(32'h12345678); wsQ.push_back(4'h5);
      writeBurst('h20, 0, 0);
      chk("model_strobe_merge", mdl['h20], 32'hFF34FF78);
      readBurst('h20, 0, 0);
      if (gotQ.size() == 1) chk("strobe_read_literal", gotQ[0], 32'hFF34FF78);

      // Len 7 with ready pattern 1,0,0.
      for (int k = 0; k < 8; k++) begin wdQ.push_back($urandom); wsQ.push_back(4'hF); end
      writeBurst('h40, 7, 0);
      rrMode = 2; rrIdx = 0;
      readBurst('h40, 7, 0);
      rrMode = 0;

      // Address rollover at the top of memory.
      for (int k = 0; k < 4; k++) begin wdQ.push_back(32'h50000000 + k); wsQ.push_back(4'hF); end
      writeBurst('h3FFFE, 3, 0);
      readBurst('h3FFFE, 3, 0);
      if (gotQ.size() == 4) chk("rollover_beat2_literal", gotQ[2], 32'h50000002);
      readBurst('h00001, 0, 0);
      if (gotQ.size() == 1) chk("rollover_addr1_literal", gotQ[0], 32'h50000003);

      // Prefill random region, then random traffic.
      for (int blk = 0; blk < 8; blk++) begin
         for (int k = 0; k < 16; k++) begin wdQ.push_back($urandom); wsQ.push_back(4'hF); end
         writeBurst('h100 + 16 * blk, 15, 0);
      end
      for (int t = 0; t < 40; t++) begin
         start = 'h100 + $urandom_range(0, 'h6F);
         len = $urandom_range(0, 15);
         wrap = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 0) begin
            for (int k = 0; k <= len; k++) begin wdQ.push_back($urandom); wsQ.push_back(4'($urandom)); end
            writeBurst(start, len, wrap);
         end else begin
            rrMode = $urandom_range(0, 2);
            readBurst(start, len, wrap);
         end
      end
      rrMode = 0;

      // Asynchronous reset while beat 2 of a read is presented.
      gotQ.delete();
      for (int i = 0; i <= 7; i++) expQ.push_back('{d: mdl['h40 + i], l: (i == 7)});
      doCmd(0, 0, 'h40, 7);
      latPending = 1;
      n = 0;
      while (gotQ.size() < 2 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("reset_reach_beat2", {31'b0, (gotQ.size() >= 2)}, 32'h1);
      resetn = 0;
      expQ.delete();
      @(negedge clk);
      chk("midreset_r_valid", {31'b0, oRValid}, 32'h0);
      chk("midreset_cmd_ready", {31'b0, oCmdReady}, 32'h1);
      chk("midreset_busy", {31'b0, oBusy}, 32'h0);
      @(posedge clk);
      #1;
      resetn = 1;
      readBurst('h10, 3, 0);
      if (gotQ.size() == 4) chk("post_reset_literal", gotQ[0], 32'hA0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
